// File: rtl/image_out_collector.sv
// Output-stream sink: snoops APB for frame side N, counts and checksums pixels,
// tracks row/col, and reports size/overflow/checksum once per Image_Done rising edge.
//
// state     | meaning
// S_IDLE    | between frames, N may be rewritten over APB
// S_COLLECT | frame in progress, N locked
// S_REPORT  | one cycle, frame_done high with report outputs valid
module image_out_collector #(
    parameter int Amba_Addr_Depth = 20,
    parameter int Amba_Word       = 16,
    parameter int Data_Depth      = 8,
    parameter int N_Addr          = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [Amba_Addr_Depth-1:0] PADDR,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [Amba_Word-1:0]       PWDATA,
    input  logic                       new_pixel,
    input  logic [Data_Depth-1:0]      Pixel_Data,
    input  logic                       Image_Done,
    output logic                       busy,
    output logic [Amba_Word-1:0]       cur_row,
    output logic [Amba_Word-1:0]       cur_col,
    output logic                       frame_done,
    output logic                       size_ok,
    output logic                       overflow_err,
    output logic [2*Amba_Word-1:0]     frame_pixels,
    output logic [31:0]                frame_checksum,
    output logic [15:0]                frame_count
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT} state_t;

    localparam logic [Amba_Addr_Depth-1:0] LP_N_ADDR = Amba_Addr_Depth'(N_Addr);

    state_t                   r_state;
    state_t                   w_next;
    logic [Amba_Word-1:0]     r_n;
    logic                     r_img_done_q;
    logic                     r_done_evt;
    logic [2*Amba_Word-1:0]   r_cnt;
    logic [31:0]              r_sum;
    logic [Amba_Word-1:0]     r_row;
    logic [Amba_Word-1:0]     r_col;
    logic                     r_ovf;
    logic                     r_size_ok;
    logic                     r_overflow_err;
    logic [2*Amba_Word-1:0]   r_frame_pixels;
    logic [31:0]              r_frame_checksum;
    logic [15:0]              r_frame_count;

    logic                     w_apb_n_wr;
    logic                     w_report;
    logic [2*Amba_Word-1:0]   w_expected;
    logic [2*Amba_Word-1:0]   w_base_cnt;
    logic [31:0]              w_base_sum;
    logic [Amba_Word-1:0]     w_base_row;
    logic [Amba_Word-1:0]     w_base_col;
    logic                     w_base_ovf;
    logic                     w_col_wrap;
    logic [2*Amba_Word-1:0]   w_cnt_nxt;
    logic [31:0]              w_sum_nxt;
    logic [Amba_Word-1:0]     w_row_nxt;
    logic [Amba_Word-1:0]     w_col_nxt;
    logic                     w_ovf_nxt;

    assign w_apb_n_wr = PSEL && PENABLE && PWRITE && (PADDR == LP_N_ADDR);
    assign w_expected = (2*Amba_Word)'(r_n) * (2*Amba_Word)'(r_n);
    assign w_report   = (r_state != S_REPORT) && r_done_evt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_done_evt)     w_next = S_REPORT;
                else if (new_pixel) w_next = S_COLLECT;
            end
            S_COLLECT: begin
                if (r_done_evt) w_next = S_REPORT;
            end
            S_REPORT: begin
                w_next = new_pixel ? S_COLLECT : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state == S_COLLECT);
        frame_done = (r_state == S_REPORT);
    end

    // REPORT clears the frame accumulators, so a pixel arriving there starts from zero.
    always_comb begin
        if (r_state == S_REPORT) begin
            w_base_cnt = '0;
            w_base_sum = '0;
            w_base_row = '0;
            w_base_col = '0;
            w_base_ovf = 1'b0;
        end else begin
            w_base_cnt = r_cnt;
            w_base_sum = r_sum;
            w_base_row = r_row;
            w_base_col = r_col;
            w_base_ovf = r_ovf;
        end
        w_col_wrap = (r_n != '0) && (w_base_col == r_n - Amba_Word'(1));
        w_cnt_nxt  = w_base_cnt;
        w_sum_nxt  = w_base_sum;
        w_row_nxt  = w_base_row;
        w_col_nxt  = w_base_col;
        w_ovf_nxt  = w_base_ovf;
        if (new_pixel) begin
            w_cnt_nxt = w_base_cnt + 1'b1;
            w_sum_nxt = w_base_sum + 32'(Pixel_Data);
            w_ovf_nxt = w_base_ovf | (w_base_cnt == w_expected);
            if (w_col_wrap) begin
                w_col_nxt = '0;
                w_row_nxt = w_base_row + 1'b1;
            end else begin
                w_col_nxt = w_base_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n              <= '0;
            r_img_done_q     <= 1'b0;
            r_done_evt       <= 1'b0;
            r_cnt            <= '0;
            r_sum            <= '0;
            r_row            <= '0;
            r_col            <= '0;
            r_ovf            <= 1'b0;
            r_size_ok        <= 1'b0;
            r_overflow_err   <= 1'b0;
            r_frame_pixels   <= '0;
            r_frame_checksum <= '0;
            r_frame_count    <= '0;
        end else begin
            r_img_done_q <= Image_Done;
            r_done_evt   <= Image_Done && !r_img_done_q;
            if ((r_state == S_IDLE) && w_apb_n_wr) r_n <= PWDATA;
            r_cnt <= w_cnt_nxt;
            r_sum <= w_sum_nxt;
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
            r_ovf <= w_ovf_nxt;
            // Latch the report on entry so it is valid for the whole frame_done cycle.
            if (w_report) begin
                r_frame_pixels   <= w_cnt_nxt;
                r_size_ok        <= (w_cnt_nxt == w_expected);
                r_overflow_err   <= w_ovf_nxt;
                r_frame_checksum <= w_sum_nxt;
                r_frame_count    <= r_frame_count + 16'd1;
            end
        end
    end

    assign cur_row        = r_row;
    assign cur_col        = r_col;
    assign size_ok        = r_size_ok;
    assign overflow_err   = r_overflow_err;
    assign frame_pixels   = r_frame_pixels;
    assign frame_checksum = r_frame_checksum;
    assign frame_count    = r_frame_count;

endmodule

// File: tb/tb_image_out_collector.sv
// Directed bench for image_out_collector: frame size, overflow, checksum,
// same-cycle pixel/done, mid-frame reset and APB writes locked out during a frame.
module tb_image_out_collector;

    logic        clk;
    logic        rst;
    logic [19:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [15:0] PWDATA;
    logic        new_pixel;
    logic [7:0]  Pixel_Data;
    logic        Image_Done;
    logic        busy;
    logic [15:0] cur_row;
    logic [15:0] cur_col;
    logic        frame_done;
    logic        size_ok;
    logic        overflow_err;
    logic [31:0] frame_pixels;
    logic [31:0] frame_checksum;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    image_out_collector #(
        .Amba_Addr_Depth(20),
        .Amba_Word(16),
        .Data_Depth(8),
        .N_Addr(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .PADDR(PADDR),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .new_pixel(new_pixel),
        .Pixel_Data(Pixel_Data),
        .Image_Done(Image_Done),
        .busy(busy),
        .cur_row(cur_row),
        .cur_col(cur_col),
        .frame_done(frame_done),
        .size_ok(size_ok),
        .overflow_err(overflow_err),
        .frame_pixels(frame_pixels),
        .frame_checksum(frame_checksum),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [19:0] addr, input logic [15:0] data);
        PADDR   = addr;
        PWDATA  = data;
        PSEL    = 1'b1;
        PWRITE  = 1'b1;
        PENABLE = 1'b0;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic send_pixels(input int count, input int start);
        for (int k = 0; k < count; k++) begin
            new_pixel  = 1'b1;
            Pixel_Data = 8'(start + k);
            tick();
        end
        new_pixel = 1'b0;
    endtask

    // Raise Image_Done (optionally with one last pixel) and watch six cycles for frame_done.
    task automatic end_frame(input string tag, input bit with_pixel, input logic [7:0] pv);
        int pulses;
        int first;
        pulses = 0;
        first  = -1;
        Image_Done = 1'b1;
        if (with_pixel) begin
            new_pixel  = 1'b1;
            Pixel_Data = pv;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_done) begin
                pulses++;
                if (first < 0) first = i;
            end
            @(posedge clk);
            #1;
            new_pixel = 1'b0;
        end
        Image_Done = 1'b0;
        check_val({tag, "_pulses"}, 64'(pulses), 64'd1);
        check_val({tag, "_latency"}, 64'(first), 64'd2);
        check_val({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int pulses;
        rst        = 1'b1;
        PADDR      = '0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        PWRITE     = 1'b0;
        PWDATA     = '0;
        new_pixel  = 1'b0;
        Pixel_Data = '0;
        Image_Done = 1'b0;
        repeat (3) tick();
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_frame_done", 64'(frame_done), 64'd0);
        check_val("rst_count", 64'(frame_count), 64'd0);
        check_val("rst_pixels", 64'(frame_pixels), 64'd0);
        rst = 1'b0;
        tick();

        // 1: N=4, 16 pixels 0..15
        apb_write(20'd2, 16'd4);
        send_pixels(5, 0);
        check_val("t1_busy", 64'(busy), 64'd1);
        check_val("t1_row5", 64'(cur_row), 64'd1);
        check_val("t1_col5", 64'(cur_col), 64'd1);
        send_pixels(11, 5);
        end_frame("t1", 1'b0, 8'd0);
        check_val("t1_size_ok", 64'(size_ok), 64'd1);
        check_val("t1_pixels", 64'(frame_pixels), 64'd16);
        check_val("t1_checksum", 64'(frame_checksum), 64'd120);
        check_val("t1_count", 64'(frame_count), 64'd1);
        check_val("t1_ovf", 64'(overflow_err), 64'd0);
        check_val("t1_row_clr", 64'(cur_row), 64'd0);

        // 2: N=3, 8 pixels 10..17 (under-size)
        apb_write(20'd2, 16'd3);
        send_pixels(8, 10);
        end_frame("t2", 1'b0, 8'd0);
        check_val("t2_size_ok", 64'(size_ok), 64'd0);
        check_val("t2_pixels", 64'(frame_pixels), 64'd8);
        check_val("t2_ovf", 64'(overflow_err), 64'd0);
        check_val("t2_checksum", 64'(frame_checksum), 64'd108);
        check_val("t2_count", 64'(frame_count), 64'd2);

        // 3: N=2, 5 pixels 200..204 (overflow)
        apb_write(20'd2, 16'd2);
        send_pixels(5, 200);
        end_frame("t3", 1'b0, 8'd0);
        check_val("t3_ovf", 64'(overflow_err), 64'd1);
        check_val("t3_size_ok", 64'(size_ok), 64'd0);
        check_val("t3_pixels", 64'(frame_pixels), 64'd5);
        check_val("t3_checksum", 64'(frame_checksum), 64'd1010);

        // 4: N=4, last pixel in the same cycle as the Image_Done rise
        apb_write(20'd2, 16'd4);
        send_pixels(15, 0);
        end_frame("t4", 1'b1, 8'd15);
        check_val("t4_pixels", 64'(frame_pixels), 64'd16);
        check_val("t4_size_ok", 64'(size_ok), 64'd1);
        check_val("t4_checksum", 64'(frame_checksum), 64'd120);
        check_val("t4_count", 64'(frame_count), 64'd4);

        // 5: reset mid-frame
        send_pixels(7, 1);
        check_val("t5_row", 64'(cur_row), 64'd1);
        check_val("t5_col", 64'(cur_col), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_done) pulses++;
        end
        #1;
        check_val("t5_no_done", 64'(pulses), 64'd0);
        check_val("t5_count", 64'(frame_count), 64'd0);
        check_val("t5_pixels", 64'(frame_pixels), 64'd0);
        check_val("t5_checksum", 64'(frame_checksum), 64'd0);
        check_val("t5_row_clr", 64'(cur_row), 64'd0);
        check_val("t5_col_clr", 64'(cur_col), 64'd0);
        check_val("t5_busy", 64'(busy), 64'd0);
        // N cleared by reset: an empty frame matches 0*0
        tick();
        end_frame("t5e", 1'b0, 8'd0);
        check_val("t5e_size_ok", 64'(size_ok), 64'd1);
        check_val("t5e_pixels", 64'(frame_pixels), 64'd0);
        check_val("t5e_count", 64'(frame_count), 64'd1);

        // 6: APB write during COLLECT is ignored
        apb_write(20'd2, 16'd4);
        send_pixels(1, 0);
        apb_write(20'd2, 16'd8);
        send_pixels(15, 1);
        end_frame("t6", 1'b0, 8'd0);
        check_val("t6_size_ok", 64'(size_ok), 64'd1);
        check_val("t6_pixels", 64'(frame_pixels), 64'd16);
        check_val("t6_ovf", 64'(overflow_err), 64'd0);
        check_val("t6_count", 64'(frame_count), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
